// File: rtl/dmem_store_sequencer.sv
// dmem_store_sequencer
//
// Buffers store requests from the execute stage in a small FIFO and turns
// each one into one or two word-wide write beats for the data memory.
// Each beat carries a word-aligned address, a shifted byte-enable mask and
// lane-aligned write data. The pipeline sees only req_ready; memory write
// acknowledgement latency is hidden behind the buffer.
//
// Configuration macro: STORE_SPLIT_EN
//   defined   - stores that cross a word boundary issue a second beat
//               (BEAT1) to the next word; misalign_err is tied to 0.
//   undefined - only the first beat is issued, the upper bytes are dropped
//               and misalign_err is set (sticky) when such a store retires.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid      store request present
//   req_ready      buffer has a free entry
//   req_ssel[1:0]  store size: 00 none, 01 byte, 10 half-word, 11 word
//   req_addr[31:0] byte address
//   req_data[31:0] right-justified store data
//   mem_we         write beat valid, held until mem_ack
//   mem_addr[31:0] word address of the beat
//   mem_be[3:0]    byte enables of the beat
//   mem_wdata[31:0] lane-aligned write data
//   mem_ack        memory accepted the current beat
//   empty          nothing buffered and no beat in flight
//   misalign_err   sticky truncation flag (split disabled only)

module dmem_store_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_ssel,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        empty,
  output logic        misalign_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [1:0]  ssel;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

`ifdef STORE_SPLIT_EN
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
`else
  typedef enum logic {IDLE, BEAT0} state_t;
`endif

  entry_t          fifo_q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  state_t          state;
  state_t          state_next;

  logic            push;
  logic            pop;
  logic            more_after_pop;

  entry_t          head;
  logic [1:0]      head_off;
  logic [3:0]      base_mask;
  logic [31:0]     data_masked;
  logic [7:0]      m8;
  logic [31:0]     beat0_addr;
  logic [31:0]     wdata_lo;
  logic            upper_nz;

`ifdef STORE_SPLIT_EN
  logic [31:0]     beat1_addr;
  logic [31:0]     wdata_hi;
`endif

  // ssel=00 requests are handshaken but never occupy an entry.
  assign req_ready = (count != CW'(DEPTH));
  assign push      = req_valid && req_ready && (req_ssel != 2'b00);

  // Only checked when popping, so count >= 1; the buffer is non-empty after
  // the pop if another entry was already waiting or one arrives this edge.
  assign more_after_pop = (count > CW'(1)) || push;

  assign empty = (count == '0) && (state == IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= '{ssel: req_ssel, addr: req_addr, data: req_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      state <= state_next;
    end
  end

  // Beat formation from the head entry. The 64-bit shifted data is never
  // built; its two halves are produced directly as a left and a right shift.
  assign head     = fifo_q[rd_ptr];
  assign head_off = head.addr[1:0];

  always_comb begin
    base_mask   = 4'b1111;
    data_masked = head.data;
    case (head.ssel)
      2'b01: begin
        base_mask   = 4'b0001;
        data_masked = {24'b0, head.data[7:0]};
      end
      2'b10: begin
        base_mask   = 4'b0011;
        data_masked = {16'b0, head.data[15:0]};
      end
      default: begin
        base_mask   = 4'b1111;
        data_masked = head.data;
      end
    endcase
  end

  assign m8         = {4'b0000, base_mask} << head_off;
  assign upper_nz   = (m8[7:4] != 4'b0000);
  assign beat0_addr = {head.addr[31:2], 2'b00};
  assign wdata_lo   = data_masked << {head_off, 3'b000};

`ifdef STORE_SPLIT_EN
  assign beat1_addr = beat0_addr + 32'd4;
  // A shift by 32 yields 0, which covers the aligned case.
  assign wdata_hi   = data_masked >> (6'd32 - {1'b0, head_off, 3'b000});
`endif

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        // Entering on the push edge lets a fresh store drive mem_we the
        // very next cycle.
        if ((count != '0) || push) state_next = BEAT0;
      end
      BEAT0: begin
        mem_we    = 1'b1;
        mem_addr  = beat0_addr;
        mem_be    = m8[3:0];
        mem_wdata = wdata_lo;
        if (mem_ack) begin
`ifdef STORE_SPLIT_EN
          if (upper_nz) begin
            state_next = BEAT1;
          end else begin
            pop        = 1'b1;
            state_next = more_after_pop ? BEAT0 : IDLE;
          end
`else
          pop        = 1'b1;
          state_next = more_after_pop ? BEAT0 : IDLE;
`endif
        end
      end
`ifdef STORE_SPLIT_EN
      BEAT1: begin
        mem_we    = 1'b1;
        mem_addr  = beat1_addr;
        mem_be    = m8[7:4];
        mem_wdata = wdata_hi;
        if (mem_ack) begin
          pop        = 1'b1;
          state_next = more_after_pop ? BEAT0 : IDLE;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef STORE_SPLIT_EN
  assign misalign_err = 1'b0;
`else
  logic misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if ((state == BEAT0) && mem_ack && upper_nz) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`endif

endmodule

// File: doc/dmem_store_sequencer.md
# dmem_store_sequencer

Buffers store requests from the execute stage and sequences them into the word-wide data memory write port. Generates word-aligned addresses, shifted byte-enable masks and shifted write data from the byte-offset and store size (SB/SH/SW), and splits stores that cross a word boundary into two write beats. Sits between the pipeline's store path and the data memory, decoupling the pipeline from memory write acknowledgement.

## Interface

- DEPTH, 4: store buffer entries; power of two, at least 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  store request present.
- req_ready  out  1  buffer can accept a request.
- req_ssel  in  2  size: 00 none, 01 byte, 10 half-word, 11 word.
- req_addr  in  32  byte address.
- req_data  in  32  store data, right-justified.
- mem_we  out  1  write beat valid; held until acknowledged.
- mem_addr  out  32  word address; bits [1:0] always 0.
- mem_be  out  4  byte enables; bit i enables mem_wdata[8i+7:8i].
- mem_wdata  out  32  lane-aligned write data.
- mem_ack  in  1  memory accepted the current beat this cycle.
- empty  out  1  no buffered stores and no beat in flight.
- misalign_err  out  1  sticky; a crossing store was truncated (see Configuration).

## Operation

- Handshake: a request is accepted on a rising edge with req_valid && req_ready. req_ready = (count != DEPTH), driven from registered count only.
- ssel=00 is accepted and discarded. No entry is written.
- The FIFO holds {ssel, addr, data}. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. There is no push when full, even if a pop happens in the same cycle.
- Beat formation for the head entry:
  - off = addr[1:0]; n = 1, 2 or 4 bytes.
  - m8 = ((1<<n)-1) << off, 8 bits.
  - d64 = ({32'b0, data masked to n bytes}) << (8*off).
  - Beat 0: mem_addr = {addr[31:2], 2'b00}, mem_be = m8[3:0], mem_wdata = d64[31:0].
  - Beat 1 (only if m8[7:4] != 0): mem_addr = beat-0 address + 4, modulo 2^32. mem_be = m8[7:4], mem_wdata = d64[63:32].
- FSM states and transitions:
  - IDLE to BEAT0 when count != 0.
  - BEAT0, mem_ack, with upper mask nonzero and split enabled: go to BEAT1.
  - BEAT0, mem_ack, otherwise: pop the head. Go to BEAT0 if another entry remains after the pop, else IDLE.
  - BEAT1, mem_ack: pop the head. Go to BEAT0 or IDLE by the same rule.
- In BEAT0 and BEAT1, mem_we = 1 and mem_addr, mem_be and mem_wdata are stable until mem_ack. In IDLE, mem_we = 0 and the other mem_* outputs are 0.
- A push and a pop may occur in the same cycle when not full; count is unchanged.
- empty = (count == 0) && state == IDLE.

## Timing

- Reset values: state IDLE, count 0, both pointers 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, req_ready 1, empty 1, misalign_err 0.
- Reset asserted mid-operation: all buffered stores are discarded. Any beat in flight is abandoned, and mem_we drops asynchronously.
- Latency: a request accepted at edge N into an empty buffer gives mem_we = 1 in the cycle after edge N.
- mem_ack in the same cycle as mem_we completes the beat at that edge. An aligned store can complete one beat per cycle.
- The back-to-back stream rate with a continuous mem_ack is one beat per cycle. There are no idle cycles between entries.
- mem_ack while mem_we = 0 is ignored.

## Configuration

- STORE_SPLIT_EN defined: word-crossing stores issue BEAT0 then BEAT1, and misalign_err is tied to 0.
- STORE_SPLIT_EN undefined: only BEAT0 is issued and the upper bytes are dropped. misalign_err is set on the BEAT0 acknowledge of any store with m8[7:4] != 0, and stays set until reset. The BEAT1 state is not built.

## Test plan

- Reset, then an SW to 0x0000_1004 with data 0xDEADBEEF and mem_ack tied 1: one beat with addr 0x1004, be 1111, wdata 0xDEADBEEF. empty returns to 1 two cycles after acceptance.
- SB to 0x1003 with data 0x12345678: one beat with addr 0x1000, be 1000, wdata 0x7800_0000. Then SH to 0x1002 with data 0xAABB: be 1100, wdata 0xAABB_0000.
- SW to 0x1002 with data 0x11223344, with STORE_SPLIT_EN: beat at 0x1000 with be 1100 and wdata 0x3344_0000, then beat at 0x1004 with be 0011 and wdata 0x0000_1122. Without STORE_SPLIT_EN: the first beat only, and misalign_err = 1 afterward.
- mem_ack held 0 while pushing 4 SW requests: req_ready = 0 after the 4th acceptance. The 5th request is not accepted and the mem_* outputs stay stable. After releasing mem_ack, the 4 beats drain in FIFO order.
- ssel=00 request followed by an SB to 0x0 with data 0xFF: only one beat, be 0001. An SH to 0xFFFF_FFFF with split enabled: the second beat goes to addr 0x0000_0000 with be 0001.
- Assert rst_n low while a beat is stalled with 2 entries buffered: mem_we = 0 immediately. After release: empty = 1 and no further beats.
